// File: rtl/cachel1_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module   : cachel1_ctrl_nway
// Brief    : N-way L1 cache controller (upgrade / write-back / miss fill)
// Revision : 1.0
// ============================================================================
module cachel1_ctrl_nway #(
  parameter int WAYS           = 4,
  parameter int WAY_W          = $clog2(WAYS),
  parameter int CYCLE_NUM_ADDR = 2,
  parameter int CYCLE_NUM_DATA = 2,
  parameter int TIMEOUT        = 16
) (
  input  logic                plusclk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                op,
  input  logic                hit,
  input  logic [WAY_W-1:0]    sel_way,
  input  logic [2*WAYS-1:0]   flag,
  input  logic                bus_get,
  input  logic                get_reply,
  output logic                bus_req,
  output logic                bus_req_op,
  output logic [3:0]          bus_req_clc,
  output logic                halt,
  output logic                tran_buf_input_sel,
  output logic [WAYS-1:0]     we_flag_vector,
  output logic [WAYS-1:0]     we_addr_vector,
  output logic [2*WAYS-1:0]   new_flag_vector,
  output logic                wb_active,
  output logic                timeout_pulse,
  output logic [2:0]          st
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_wb_req  = 3'd1;
  localparam logic [2:0] c_wb_xfer = 3'd2;
  localparam logic [2:0] c_rd_req  = 3'd3;
  localparam logic [2:0] c_rd_addr = 3'd4;
  localparam logic [2:0] c_rd_wait = 3'd5;
  localparam logic [2:0] c_upd     = 3'd6;

  localparam logic [3:0] c_clc_addr  = 4'(CYCLE_NUM_ADDR);
  localparam logic [3:0] c_clc_data  = 4'(CYCLE_NUM_DATA);
  localparam logic [3:0] c_addr_last = 4'(CYCLE_NUM_ADDR - 1);
  localparam logic [3:0] c_data_last = 4'(CYCLE_NUM_DATA - 1);
  localparam logic [7:0] c_tmo_last  = 8'(TIMEOUT - 1);

  logic [2:0]       r_st;
  logic [2:0]       w_st_nxt;
  logic [3:0]       r_phase;
  logic [7:0]       r_tmo;
  logic             r_tmo_pulse;
  logic             r_op;
  logic             r_miss;
  logic [WAY_W-1:0] r_way;
  logic [1:0]       w_f;
  logic             w_miss;
  logic             w_need;
  logic [2:0]       w_idle_tgt;
  logic             w_tmo_fire;
  logic [WAYS-1:0]  w_way_oh;
  logic [1:0]       w_new_flag;

  // Request decode on the live inputs; only consulted in IDLE.
  always_comb begin
    w_f = 2'd0;
    for (int i = 0; i < WAYS; i++) begin
      if (sel_way == WAY_W'(i)) w_f = flag[2*i +: 2];
    end
    w_miss     = !hit || (w_f == 2'd0);
    w_need     = 1'b0;
    w_idle_tgt = c_idle;
    if (w_miss) begin
      w_need     = 1'b1;
      w_idle_tgt = (w_f == 2'd3) ? c_wb_req : c_rd_req;
    end else if (op) begin
      if (w_f == 2'd2) begin
        w_need     = 1'b1;
        w_idle_tgt = c_upd;
      end else if (w_f == 2'd1) begin
        w_need     = 1'b1;
        w_idle_tgt = c_wb_req;
      end
    end
  end

  always_ff @(posedge plusclk or negedge rst) begin
    if (!rst) r_st <= c_idle;
    else      r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_tmo_fire = 1'b0;
    case (r_st)
      c_idle:    if (req_valid && w_need) w_st_nxt = w_idle_tgt;
      c_wb_req:  if (bus_get) w_st_nxt = c_wb_xfer;
      c_wb_xfer: if (r_phase == c_data_last) w_st_nxt = r_miss ? c_rd_req : c_upd;
      c_rd_req:  if (bus_get) w_st_nxt = c_rd_addr;
      c_rd_addr: if (r_phase == c_addr_last) w_st_nxt = c_rd_wait;
      c_rd_wait: begin
        // A reply arriving on the last timeout cycle still completes the fill.
        if (get_reply) begin
          w_st_nxt = c_upd;
        end else if (r_tmo == c_tmo_last) begin
          w_st_nxt   = c_rd_req;
          w_tmo_fire = 1'b1;
        end
      end
      c_upd:     w_st_nxt = c_idle;
      default:   w_st_nxt = c_idle;
    endcase
  end

  always_ff @(posedge plusclk or negedge rst) begin
    if (!rst) begin
      r_phase     <= 4'd0;
      r_tmo       <= 8'd0;
      r_tmo_pulse <= 1'b0;
      r_op        <= 1'b0;
      r_miss      <= 1'b0;
      r_way       <= '0;
    end else begin
      r_tmo_pulse <= w_tmo_fire;
      if (w_st_nxt != r_st) begin
        r_phase <= 4'd0;
        r_tmo   <= 8'd0;
      end else begin
        if (r_phase != 4'hF) r_phase <= r_phase + 4'd1;
        if (r_tmo != 8'hFF)  r_tmo   <= r_tmo + 8'd1;
      end
      if (r_st == c_idle && req_valid) begin
        r_op   <= op;
        r_miss <= w_miss;
        r_way  <= sel_way;
      end
    end
  end

  assign w_way_oh   = {{(WAYS-1){1'b0}}, 1'b1} << r_way;
  assign w_new_flag = (r_miss && !r_op) ? 2'd1 : 2'd3;

  always_comb begin
    bus_req            = (r_st == c_wb_req) || (r_st == c_rd_req);
    bus_req_op         = (r_st == c_wb_req);
    bus_req_clc        = (r_st == c_wb_req) ? c_clc_data :
                         (r_st == c_rd_req) ? c_clc_addr : 4'd0;
    tran_buf_input_sel = (r_st == c_wb_req) || (r_st == c_wb_xfer);
    wb_active          = (r_st == c_wb_xfer);
    we_flag_vector     = (r_st == c_upd) ? w_way_oh : '0;
    we_addr_vector     = (r_st == c_upd && r_miss) ? w_way_oh : '0;
    new_flag_vector    = (r_st == c_upd) ? {WAYS{w_new_flag}} : '0;
    timeout_pulse      = r_tmo_pulse;
    st                 = r_st;
    // Gated by rst so the IDLE look-ahead stays quiet while in reset.
    halt               = rst && ((r_st != c_idle) || (req_valid && w_need));
  end

endmodule
`default_nettype wire
